core_decode_stage: RTL and testbench
====================================

# core_decode_stage

Registered RV32I instruction-decode pipeline stage. It sits between fetch and execute and decodes every base-ISA format (R/I/S/B/U/J) into flat control fields with fully sign-extended immediates. It flags illegal encodings and, optionally, decodes the M extension. A valid/ready handshake with a one-entry skid buffer decouples fetch from execute back-pressure, and a flush input discards in-flight instructions.

## Interface
- XLEN, 32: datapath width for `pc` and `imm`. Legal values are 32 and 64; immediates sign-extend to XLEN.
- NUM_REGS, 32: architectural register count, 32 or 16 (RV32E). Any rs1/rs2/rd index ≥ NUM_REGS is illegal.
- EN_MULDIV, 0: 1 makes funct7=0000001 OP encodings legal (M extension).

Ports:
- clk_i  in  1  clock, rising edge.
- arst_i  in  1  reset, asynchronous, active-high.
- flush_i  in  1  discard skid and output contents.
- in_valid_i  in  1  fetch offers an instruction.
- in_ready_o  out  1  stage can accept; registered.
- in_instr_i  in  32  instruction word.
- in_pc_i  in  XLEN  instruction address.
- out_valid_o  out  1  decoded instruction present.
- out_ready_i  in  1  execute accepts.
- out_pc_o  out  XLEN  PC of the decoded instruction.
- out_rs1_o, out_rs2_o, out_rd_o  out  5  register indices.
- out_imm_o  out  XLEN  sign-extended immediate for the decoded format; 0 for R-type.
- out_alu_op_o  out  4  ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9.
- out_op_a_sel_o  out  1  0=rs1, 1=PC (AUIPC/JAL/branch target).
- out_op_b_sel_o  out  1  0=rs2, 1=imm.
- out_rd_we_o, out_is_load_o, out_is_store_o, out_is_branch_o, out_is_jump_o, out_is_mdu_o  out  1 each.
- out_funct3_o  out  3  raw funct3, used for branch condition, memory size/sign and MDU op.
- out_illegal_o  out  1  illegal encoding.

## Operation
- **Decode.** Combinational from the selected source: the skid entry if it is valid, otherwise `in_instr_i`.
- **Immediates.**
  - I: instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U: {instr[31:12], 12'b0}.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - All formats sign-extend from instr[31].
- **ALU op.**
  - OP-IMM: funct3 maps directly; funct3=101 selects SRA when instr[30]=1.
  - OP: additionally, instr[30]=1 with funct3=000 selects SUB.
  - LUI: ADD, op_a = rs1 with rs1 forced to 0.
  - Loads, stores, JALR: ADD, op_b = imm.
  - Branches: SUB, or SLT/SLTU per funct3.
- **rd_we.** 1 for LUI, AUIPC, JAL, JALR, OP, OP-IMM, LOAD. 0 otherwise, and 0 whenever illegal=1.
- **Illegal conditions:**
  - instr[1:0] ≠ 11.
  - Unsupported opcode; FENCE and SYSTEM are decoded as legal NOPs.
  - funct3 010/011/111 on BRANCH-adjacent slots: BRANCH funct3 010/011, LOAD funct3 011/110/111, STORE funct3 ≥ 011.
  - OP funct7 not in {0000000, 0100000 with funct3 000/101, 0000001 if EN_MULDIV}.
  - Shift-immediate funct7 bad.
  - A used register index ≥ NUM_REGS.
- **Illegal pass-through.** Illegal instructions still flow through with out_illegal_o=1 and all side-effect flags (we/load/store/branch/jump/mdu) forced to 0.
- **Handshake.**
  - Transfer happens on `valid & ready` at each side.
  - The output register loads when `!out_valid_o || out_ready_i`.
  - If the output is stalled (out_valid_o & !out_ready_i) and an input transfer occurs, the input is captured in the skid; in_ready_o falls the next cycle.
  - When the skid is valid and the output frees, the skid moves to the output, the skid clears, and in_ready_o rises the next cycle.
- **Flush.** flush_i clears out_valid_o and the skid valid on the next edge. An input presented in the flush cycle is dropped. in_ready_o = 1 after the flush.

## Timing
- Reset values: out_valid_o=0, in_ready_o=1, skid empty, all out_* data = 0.
- Latency: 1 cycle from in_valid_i&in_ready_o to out_valid_o. Throughput is 1 per cycle with no back-pressure.
- in_ready_o = !skid_valid, registered; it never depends combinationally on out_ready_i.
- Simultaneous events:
  - Skid valid, out_ready_i=1 and in_valid_i=1: the skid goes to the output, and the input is not accepted because in_ready_o=0 that cycle.
  - Output valid, out_ready_i=1 and an input transfer: the input replaces the output directly.
- flush_i has priority over every load.
- Reset asserted mid-transfer clears everything asynchronously. No instruction is emitted after reset release until a new input is accepted.
- Output data is held stable while out_valid_o & !out_ready_i.

## Test plan
- **Decode check.** Reset, out_ready_i=1, feed 0xFFF10093 (addi x1,x2,-1) → next cycle:
  - out_valid_o=1, rs1=2, rd=1, imm=0xFFFFFFFF.
  - alu_op=ADD, op_b_sel=1, rd_we=1, illegal=0.
- **Immediate formats.** Each instruction below → expected fields:
  - 0x00512423 (sw x5,8(x2)): imm=8, is_store=1, rd_we=0, funct3=010.
  - 0x008000EF (jal x1,+8): imm=8, is_jump=1, op_a_sel=1.
  - 0x123452B7 (lui x5,0x12345): imm=0x12345000.
- **SUB and illegal checks.**
  - 0x402081B3 → alu_op=SUB.
  - 0x022081B3 with EN_MULDIV=0 → illegal=1, rd_we=0.
  - 0x022081B3 with EN_MULDIV=1 → is_mdu=1, illegal=0.
  - NUM_REGS=16 with 0x00000833 (rd=16) → illegal=1.
- **Back-pressure.** Hold out_ready_i=0 and stream instructions A, B, C:
  - A is held on the output, B goes to the skid, in_ready_o=0, C waits.
  - Release out_ready_i → B emerges the next cycle, in_ready_o=1, C emerges after B.
  - Order is preserved and no instruction is lost or duplicated.
- **Flush.** Output and skid both full, assert flush_i with in_valid_i=1 → next cycle out_valid_o=0, in_ready_o=1, and the flushed and concurrent inputs never appear.
- **Mid-stream reset.** Assert arst_i while streaming → outputs return to reset values immediately (asynchronously), and no stale instruction appears after reset release.

Source files
------------

// File: rtl/core_decode_stage_if.sv
// Fetch-to-execute handshake bundle for the RV32I decode stage.
// The fetch/execute environment drives through master; the stage connects to slave.
interface core_decode_stage_if #(
  parameter int XLEN = 32
);
  logic            in_valid_i;
  logic            in_ready_o;
  logic [31:0]     in_instr_i;
  logic [XLEN-1:0] in_pc_i;

  logic            out_valid_o;
  logic            out_ready_i;
  logic [XLEN-1:0] out_pc_o;
  logic [4:0]      out_rs1_o;
  logic [4:0]      out_rs2_o;
  logic [4:0]      out_rd_o;
  logic [XLEN-1:0] out_imm_o;
  logic [3:0]      out_alu_op_o;
  logic            out_op_a_sel_o;
  logic            out_op_b_sel_o;
  logic            out_rd_we_o;
  logic            out_is_load_o;
  logic            out_is_store_o;
  logic            out_is_branch_o;
  logic            out_is_jump_o;
  logic            out_is_mdu_o;
  logic [2:0]      out_funct3_o;
  logic            out_illegal_o;

  modport master (
    output in_valid_i, in_instr_i, in_pc_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_pc_o, out_rs1_o, out_rs2_o, out_rd_o,
           out_imm_o, out_alu_op_o, out_op_a_sel_o, out_op_b_sel_o, out_rd_we_o,
           out_is_load_o, out_is_store_o, out_is_branch_o, out_is_jump_o,
           out_is_mdu_o, out_funct3_o, out_illegal_o
  );

  modport slave (
    input  in_valid_i, in_instr_i, in_pc_i, out_ready_i,
    output in_ready_o, out_valid_o, out_pc_o, out_rs1_o, out_rs2_o, out_rd_o,
           out_imm_o, out_alu_op_o, out_op_a_sel_o, out_op_b_sel_o, out_rd_we_o,
           out_is_load_o, out_is_store_o, out_is_branch_o, out_is_jump_o,
           out_is_mdu_o, out_funct3_o, out_illegal_o
  );
endinterface

// File: rtl/core_decode_stage.sv
// Registered RV32I decode stage with one-entry skid buffer and flush.
// Decodes the skid entry when occupied, otherwise the incoming fetch word.
module core_decode_stage #(
  parameter int XLEN      = 32,
  parameter int NUM_REGS  = 32,
  parameter bit EN_MULDIV = 1'b0
) (
  input logic                clk_i,
  input logic                arst_i,
  input logic                flush_i,
  core_decode_stage_if.slave bus
);

  typedef enum logic [6:0] {
    OPC_LOAD     = 7'b0000011,
    OPC_MISC_MEM = 7'b0001111,
    OPC_OP_IMM   = 7'b0010011,
    OPC_AUIPC    = 7'b0010111,
    OPC_STORE    = 7'b0100011,
    OPC_OP       = 7'b0110011,
    OPC_LUI      = 7'b0110111,
    OPC_BRANCH   = 7'b1100011,
    OPC_JALR     = 7'b1100111,
    OPC_JAL      = 7'b1101111,
    OPC_SYSTEM   = 7'b1110011
  } opcode_e;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;

  typedef struct packed {
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    alu_op_e         alu_op;
    logic            op_a_sel;
    logic            op_b_sel;
    logic            rd_we;
    logic            is_load;
    logic            is_store;
    logic            is_branch;
    logic            is_jump;
    logic            is_mdu;
    logic [2:0]      funct3;
    logic            illegal;
  } dec_t;

  localparam logic [5:0] REG_LIMIT = 6'(NUM_REGS);

  function automatic alu_op_e alu_base(input logic [2:0] f3);
    case (f3)
      3'b000:  return ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] sext(input logic [31:0] v);
    return XLEN'($signed(v));
  endfunction

  function automatic logic reg_bad(input logic [4:0] idx);
    return {1'b0, idx} >= REG_LIMIT;
  endfunction

  logic            skid_valid;
  logic [31:0]     skid_instr;
  logic [XLEN-1:0] skid_pc;
  logic            in_ready_q;
  logic            out_valid_q;
  logic [XLEN-1:0] out_pc_q;
  dec_t            dec_q;

  logic [31:0]     sel_instr;
  logic [XLEN-1:0] sel_pc;
  dec_t            dec;
  logic [6:0]      opcode;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic [31:0]     imm_i, imm_s, imm_b, imm_u, imm_j;
  logic            use_rs1, use_rs2, use_rd, bad;
  logic            in_fire, out_free;

  always_comb begin
    sel_instr = skid_valid ? skid_instr : bus.in_instr_i;
    sel_pc    = skid_valid ? skid_pc    : bus.in_pc_i;
  end

  always_comb begin
    opcode = sel_instr[6:0];
    f3     = sel_instr[14:12];
    f7     = sel_instr[31:25];
    imm_i  = {{20{sel_instr[31]}}, sel_instr[31:20]};
    imm_s  = {{20{sel_instr[31]}}, sel_instr[31:25], sel_instr[11:7]};
    imm_b  = {{19{sel_instr[31]}}, sel_instr[31], sel_instr[7], sel_instr[30:25],
              sel_instr[11:8], 1'b0};
    imm_u  = {sel_instr[31:12], 12'b0};
    imm_j  = {{11{sel_instr[31]}}, sel_instr[31], sel_instr[19:12], sel_instr[20],
              sel_instr[30:21], 1'b0};

    dec        = '0;
    dec.funct3 = f3;
    use_rs1    = 1'b0;
    use_rs2    = 1'b0;
    use_rd     = 1'b0;
    bad        = 1'b0;

    case (opcode)
      OPC_LUI: begin
        use_rd       = 1'b1;
        dec.imm      = sext(imm_u);
        dec.op_b_sel = 1'b1;
        dec.rd_we    = 1'b1;
      end
      OPC_AUIPC: begin
        use_rd       = 1'b1;
        dec.imm      = sext(imm_u);
        dec.op_a_sel = 1'b1;
        dec.op_b_sel = 1'b1;
        dec.rd_we    = 1'b1;
      end
      OPC_JAL: begin
        use_rd       = 1'b1;
        dec.imm      = sext(imm_j);
        dec.op_a_sel = 1'b1;
        dec.op_b_sel = 1'b1;
        dec.rd_we    = 1'b1;
        dec.is_jump  = 1'b1;
      end
      OPC_JALR: begin
        use_rs1      = 1'b1;
        use_rd       = 1'b1;
        dec.imm      = sext(imm_i);
        dec.op_b_sel = 1'b1;
        dec.rd_we    = 1'b1;
        dec.is_jump  = 1'b1;
      end
      OPC_BRANCH: begin
        use_rs1       = 1'b1;
        use_rs2       = 1'b1;
        dec.imm       = sext(imm_b);
        dec.op_a_sel  = 1'b1;
        dec.op_b_sel  = 1'b1;
        dec.is_branch = 1'b1;
        dec.alu_op    = f3[2] ? (f3[1] ? ALU_SLTU : ALU_SLT) : ALU_SUB;
        bad           = (f3[2:1] == 2'b01);
      end
      OPC_LOAD: begin
        use_rs1      = 1'b1;
        use_rd       = 1'b1;
        dec.imm      = sext(imm_i);
        dec.op_b_sel = 1'b1;
        dec.rd_we    = 1'b1;
        dec.is_load  = 1'b1;
        bad          = (f3 == 3'b011) || (f3[2:1] == 2'b11);
      end
      OPC_STORE: begin
        use_rs1      = 1'b1;
        use_rs2      = 1'b1;
        dec.imm      = sext(imm_s);
        dec.op_b_sel = 1'b1;
        dec.is_store = 1'b1;
        bad          = f3[2] || (f3[1:0] == 2'b11);
      end
      OPC_OP_IMM: begin
        use_rs1      = 1'b1;
        use_rd       = 1'b1;
        dec.imm      = sext(imm_i);
        dec.op_b_sel = 1'b1;
        dec.rd_we    = 1'b1;
        dec.alu_op   = alu_base(f3);
        // Shift immediates reuse imm[11:5] as a funct7 qualifier.
        if (f3 == 3'b001) begin
          bad = (f7 != 7'b0000000);
        end else if (f3 == 3'b101) begin
          bad = (f7 != 7'b0000000) && (f7 != 7'b0100000);
          if (sel_instr[30]) dec.alu_op = ALU_SRA;
        end
      end
      OPC_OP: begin
        use_rs1    = 1'b1;
        use_rs2    = 1'b1;
        use_rd     = 1'b1;
        dec.rd_we  = 1'b1;
        dec.alu_op = alu_base(f3);
        case (f7)
          7'b0000000: ;
          7'b0100000: begin
            if (f3 == 3'b000)      dec.alu_op = ALU_SUB;
            else if (f3 == 3'b101) dec.alu_op = ALU_SRA;
            else                   bad = 1'b1;
          end
          7'b0000001: begin
            if (EN_MULDIV) begin
              dec.is_mdu = 1'b1;
              dec.alu_op = ALU_ADD;
            end else begin
              bad = 1'b1;
            end
          end
          default: bad = 1'b1;
        endcase
      end
      OPC_MISC_MEM, OPC_SYSTEM: ;
      default: bad = 1'b1;
    endcase

    if (sel_instr[1:0] != 2'b11) bad = 1'b1;
    if ((use_rs1 && reg_bad(sel_instr[19:15])) ||
        (use_rs2 && reg_bad(sel_instr[24:20])) ||
        (use_rd  && reg_bad(sel_instr[11:7])))
      bad = 1'b1;

    // Index fields a format does not use are reported as x0.
    dec.rs1 = use_rs1 ? sel_instr[19:15] : 5'd0;
    dec.rs2 = use_rs2 ? sel_instr[24:20] : 5'd0;
    dec.rd  = use_rd  ? sel_instr[11:7]  : 5'd0;

    if (bad) begin
      dec.illegal   = 1'b1;
      dec.rd_we     = 1'b0;
      dec.is_load   = 1'b0;
      dec.is_store  = 1'b0;
      dec.is_branch = 1'b0;
      dec.is_jump   = 1'b0;
      dec.is_mdu    = 1'b0;
    end
  end

  assign in_fire  = bus.in_valid_i & in_ready_q;
  assign out_free = ~out_valid_q | bus.out_ready_i;

  // in_ready mirrors !skid_valid as a register, so it never sees out_ready combinationally.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      skid_valid  <= 1'b0;
      skid_instr  <= '0;
      skid_pc     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_pc_q    <= '0;
      dec_q       <= '0;
    end else if (flush_i) begin
      skid_valid  <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else if (out_free) begin
      out_valid_q <= skid_valid | in_fire;
      if (skid_valid | in_fire) begin
        dec_q    <= dec;
        out_pc_q <= sel_pc;
      end
      skid_valid <= 1'b0;
      in_ready_q <= 1'b1;
    end else if (in_fire) begin
      skid_valid <= 1'b1;
      skid_instr <= bus.in_instr_i;
      skid_pc    <= bus.in_pc_i;
      in_ready_q <= 1'b0;
    end
  end

  assign bus.in_ready_o      = in_ready_q;
  assign bus.out_valid_o     = out_valid_q;
  assign bus.out_pc_o        = out_pc_q;
  assign bus.out_rs1_o       = dec_q.rs1;
  assign bus.out_rs2_o       = dec_q.rs2;
  assign bus.out_rd_o        = dec_q.rd;
  assign bus.out_imm_o       = dec_q.imm;
  assign bus.out_alu_op_o    = dec_q.alu_op;
  assign bus.out_op_a_sel_o  = dec_q.op_a_sel;
  assign bus.out_op_b_sel_o  = dec_q.op_b_sel;
  assign bus.out_rd_we_o     = dec_q.rd_we;
  assign bus.out_is_load_o   = dec_q.is_load;
  assign bus.out_is_store_o  = dec_q.is_store;
  assign bus.out_is_branch_o = dec_q.is_branch;
  assign bus.out_is_jump_o   = dec_q.is_jump;
  assign bus.out_is_mdu_o    = dec_q.is_mdu;
  assign bus.out_funct3_o    = dec_q.funct3;
  assign bus.out_illegal_o   = dec_q.illegal;

endmodule

// File: tb/tb_core_decode_stage.sv
// Bench for core_decode_stage: directed decode/handshake/flush/reset steps, then a
// random stream checked against an assembler-style model and an in-order scoreboard.
module tb_core_decode_stage;
  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic arst;
  logic flush;
  always #5 clk = ~clk;

  core_decode_stage_if #(.XLEN(XLEN)) bus ();
  core_decode_stage_if #(.XLEN(XLEN)) bus_m ();
  core_decode_stage_if #(.XLEN(XLEN)) bus_e ();

  assign bus_m.in_valid_i  = bus.in_valid_i;
  assign bus_m.in_instr_i  = bus.in_instr_i;
  assign bus_m.in_pc_i     = bus.in_pc_i;
  assign bus_m.out_ready_i = bus.out_ready_i;
  assign bus_e.in_valid_i  = bus.in_valid_i;
  assign bus_e.in_instr_i  = bus.in_instr_i;
  assign bus_e.in_pc_i     = bus.in_pc_i;
  assign bus_e.out_ready_i = bus.out_ready_i;

  core_decode_stage #(.XLEN(XLEN), .NUM_REGS(32), .EN_MULDIV(1'b0)) dut (
    .clk_i(clk), .arst_i(arst), .flush_i(flush), .bus(bus.slave));
  core_decode_stage #(.XLEN(XLEN), .NUM_REGS(32), .EN_MULDIV(1'b1)) dut_m (
    .clk_i(clk), .arst_i(arst), .flush_i(flush), .bus(bus_m.slave));
  core_decode_stage #(.XLEN(XLEN), .NUM_REGS(16), .EN_MULDIV(1'b0)) dut_e (
    .clk_i(clk), .arst_i(arst), .flush_i(flush), .bus(bus_e.slave));

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [3:0]  alu;
    logic        a_sel;
    logic        b_sel;
    logic        we;
    logic        ld;
    logic        st;
    logic        br;
    logic        jp;
    logic        mdu;
    logic [2:0]  f3;
    logic        ill;
  } exp_t;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] sx(input logic [31:0] v, input int unsigned n);
    logic [31:0] t;
    t = v << (32 - n);
    return 32'($signed(t) >>> (32 - n));
  endfunction

  function automatic logic [3:0] alu_of(input logic [2:0] f3);
    case (f3)
      3'd0: return 4'd0;
      3'd1: return 4'd2;
      3'd2: return 4'd3;
      3'd3: return 4'd4;
      3'd4: return 4'd5;
      3'd5: return 4'd6;
      3'd6: return 4'd8;
      default: return 4'd9;
    endcase
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] opc);
    return {imm, rs1, f3, rd, opc};
  endfunction
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  // Assemble a random instruction and state what a correct decoder must report.
  task automatic gen(input logic [31:0] pc, output exp_t e);
    int unsigned kind, k;
    logic [4:0]  r1, r2, rd;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [11:0] i12;
    logic [19:0] u20;
    logic [20:0] j21;
    logic [12:0] b13;
    kind = $urandom_range(0, 12);
    k    = $urandom_range(0, 9);
    r1   = 5'($urandom);
    r2   = 5'($urandom);
    rd   = 5'($urandom);
    i12  = 12'($urandom);
    u20  = 20'($urandom);
    j21  = {20'($urandom), 1'b0};
    b13  = {12'($urandom), 1'b0};
    e    = '0;
    e.pc = pc;
    case (kind)
      0: begin
        case (k % 6)
          0: f3 = 3'd0; 1: f3 = 3'd2; 2: f3 = 3'd3;
          3: f3 = 3'd4; 4: f3 = 3'd6; default: f3 = 3'd7;
        endcase
        e.instr = enc_i(i12, r1, f3, rd, 7'b0010011);
        e.rs1 = r1; e.rd = rd; e.imm = sx({20'd0, i12}, 12);
        e.alu = alu_of(f3); e.b_sel = 1; e.we = 1;
      end
      1: begin
        case (k % 3)
          0: begin f3 = 3'd1; f7 = 7'h00; e.alu = 4'd2; end
          1: begin f3 = 3'd5; f7 = 7'h00; e.alu = 4'd6; end
          default: begin f3 = 3'd5; f7 = 7'h20; e.alu = 4'd7; end
        endcase
        i12 = {f7, 5'($urandom)};
        e.instr = enc_i(i12, r1, f3, rd, 7'b0010011);
        e.rs1 = r1; e.rd = rd; e.imm = {20'd0, i12}; e.b_sel = 1; e.we = 1;
      end
      2: begin
        case (k)
          0: begin f3 = 3'd0; f7 = 7'h00; e.alu = 4'd0; end
          1: begin f3 = 3'd0; f7 = 7'h20; e.alu = 4'd1; end
          2: begin f3 = 3'd1; f7 = 7'h00; e.alu = 4'd2; end
          3: begin f3 = 3'd2; f7 = 7'h00; e.alu = 4'd3; end
          4: begin f3 = 3'd3; f7 = 7'h00; e.alu = 4'd4; end
          5: begin f3 = 3'd4; f7 = 7'h00; e.alu = 4'd5; end
          6: begin f3 = 3'd5; f7 = 7'h00; e.alu = 4'd6; end
          7: begin f3 = 3'd5; f7 = 7'h20; e.alu = 4'd7; end
          8: begin f3 = 3'd6; f7 = 7'h00; e.alu = 4'd8; end
          default: begin f3 = 3'd7; f7 = 7'h00; e.alu = 4'd9; end
        endcase
        e.instr = enc_r(f7, r2, r1, f3, rd);
        e.rs1 = r1; e.rs2 = r2; e.rd = rd; e.we = 1;
      end
      3: begin
        e.instr = enc_r(7'h01, r2, r1, 3'($urandom), rd);
        e.ill = 1;
      end
      4: begin
        e.instr = {u20, rd, 7'b0110111};
        e.rd = rd; e.imm = {u20, 12'd0}; e.b_sel = 1; e.we = 1;
      end
      5: begin
        e.instr = {u20, rd, 7'b0010111};
        e.rd = rd; e.imm = {u20, 12'd0}; e.a_sel = 1; e.b_sel = 1; e.we = 1;
      end
      6: begin
        e.instr = enc_j(j21, rd);
        e.rd = rd; e.imm = sx({11'd0, j21}, 21); e.a_sel = 1; e.b_sel = 1;
        e.we = 1; e.jp = 1;
      end
      7: begin
        e.instr = enc_i(i12, r1, 3'd0, rd, 7'b1100111);
        e.rs1 = r1; e.rd = rd; e.imm = sx({20'd0, i12}, 12); e.b_sel = 1;
        e.we = 1; e.jp = 1;
      end
      8: begin
        case (k % 6)
          0: begin f3 = 3'd0; e.alu = 4'd1; end
          1: begin f3 = 3'd1; e.alu = 4'd1; end
          2: begin f3 = 3'd4; e.alu = 4'd3; end
          3: begin f3 = 3'd5; e.alu = 4'd3; end
          4: begin f3 = 3'd6; e.alu = 4'd4; end
          default: begin f3 = 3'd7; e.alu = 4'd4; end
        endcase
        e.instr = enc_b(b13, r2, r1, f3);
        e.rs1 = r1; e.rs2 = r2; e.imm = sx({19'd0, b13}, 13);
        e.a_sel = 1; e.b_sel = 1; e.br = 1;
      end
      9: begin
        case (k % 5)
          0: f3 = 3'd0; 1: f3 = 3'd1; 2: f3 = 3'd2; 3: f3 = 3'd4; default: f3 = 3'd5;
        endcase
        e.instr = enc_i(i12, r1, f3, rd, 7'b0000011);
        e.rs1 = r1; e.rd = rd; e.imm = sx({20'd0, i12}, 12); e.b_sel = 1;
        e.we = 1; e.ld = 1;
      end
      10: begin
        f3 = 3'(k % 3);
        e.instr = enc_s(i12, r2, r1, f3);
        e.rs1 = r1; e.rs2 = r2; e.imm = sx({20'd0, i12}, 12); e.b_sel = 1; e.st = 1;
      end
      11: begin
        e.instr = k[0] ? 32'h0000_0073 : 32'h0ff0_000f;
      end
      default: begin
        case (k % 7)
          0: e.instr = 32'($urandom) & 32'hffff_fffc;
          1: e.instr = enc_b(b13, r2, r1, {2'b01, 1'($urandom)});
          2: e.instr = enc_i(i12, r1, (k[0] ? 3'd3 : 3'd6 + 3'(k[1])), rd, 7'b0000011);
          3: e.instr = enc_s(i12, r2, r1, 3'd3 + 3'($urandom_range(0, 4)));
          4: e.instr = enc_r(7'h20, r2, r1, k[1] ? 3'd1 : 3'd6, rd);
          5: e.instr = enc_i({7'($urandom_range(1, 127)), 5'($urandom)}, r1, 3'd1, rd,
                             7'b0010011);
          default: e.instr = {25'($urandom), 7'b1111111};
        endcase
        e.ill = 1;
      end
    endcase
    e.f3 = e.instr[14:12];
  endtask

  task automatic check_out(input string tag, input exp_t e);
    chk({tag, ".pc"},      bus.out_pc_o,        e.pc);
    chk({tag, ".illegal"}, bus.out_illegal_o,   e.ill);
    chk({tag, ".rd_we"},   bus.out_rd_we_o,     e.we);
    chk({tag, ".load"},    bus.out_is_load_o,   e.ld);
    chk({tag, ".store"},   bus.out_is_store_o,  e.st);
    chk({tag, ".branch"},  bus.out_is_branch_o, e.br);
    chk({tag, ".jump"},    bus.out_is_jump_o,   e.jp);
    chk({tag, ".mdu"},     bus.out_is_mdu_o,    e.mdu);
    if (!e.ill) begin
      chk({tag, ".rs1"},    bus.out_rs1_o,      e.rs1);
      chk({tag, ".rs2"},    bus.out_rs2_o,      e.rs2);
      chk({tag, ".rd"},     bus.out_rd_o,       e.rd);
      chk({tag, ".imm"},    bus.out_imm_o,      e.imm);
      chk({tag, ".alu"},    bus.out_alu_op_o,   e.alu);
      chk({tag, ".a_sel"},  bus.out_op_a_sel_o, e.a_sel);
      chk({tag, ".b_sel"},  bus.out_op_b_sel_o, e.b_sel);
      chk({tag, ".funct3"}, bus.out_funct3_o,   e.f3);
    end
  endtask

  task automatic present(input logic [31:0] instr, input logic [31:0] pc);
    @(negedge clk);
    flush = 0; bus.out_ready_i = 1; bus.in_valid_i = 1;
    bus.in_instr_i = instr; bus.in_pc_i = pc;
    @(negedge clk);
    bus.in_valid_i = 0;
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                       input logic rdy, input logic fl);
    @(negedge clk);
    bus.in_valid_i = v; bus.in_instr_i = instr; bus.in_pc_i = pc;
    bus.out_ready_i = rdy; flush = fl;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t        q[$];
    exp_t        cur;
    logic        have;
    logic        fired, fl, rdy;
    logic [31:0] pcn;

    arst = 1; flush = 0;
    bus.in_valid_i = 0; bus.in_instr_i = '0; bus.in_pc_i = '0; bus.out_ready_i = 0;
    #2;
    chk("rst.out_valid", bus.out_valid_o, 0);
    chk("rst.in_ready",  bus.in_ready_o,  1);
    chk("rst.pc",        bus.out_pc_o,    0);
    chk("rst.imm",       bus.out_imm_o,   0);
    chk("rst.rd_we",     bus.out_rd_we_o, 0);
    #10 arst = 0;

    present(32'hFFF10093, 32'h0000_0040);
    chk("addi.valid", bus.out_valid_o,    1);
    chk("addi.pc",    bus.out_pc_o,       32'h40);
    chk("addi.rs1",   bus.out_rs1_o,      2);
    chk("addi.rd",    bus.out_rd_o,       1);
    chk("addi.imm",   bus.out_imm_o,      32'hFFFF_FFFF);
    chk("addi.alu",   bus.out_alu_op_o,   0);
    chk("addi.b_sel", bus.out_op_b_sel_o, 1);
    chk("addi.we",    bus.out_rd_we_o,    1);
    chk("addi.ill",   bus.out_illegal_o,  0);

    present(32'h00512423, 32'h44);
    chk("sw.imm",   bus.out_imm_o,      8);
    chk("sw.store", bus.out_is_store_o, 1);
    chk("sw.we",    bus.out_rd_we_o,    0);
    chk("sw.f3",    bus.out_funct3_o,   3'b010);
    present(32'h008000EF, 32'h48);
    chk("jal.imm",   bus.out_imm_o,      8);
    chk("jal.jump",  bus.out_is_jump_o,  1);
    chk("jal.a_sel", bus.out_op_a_sel_o, 1);
    present(32'h123452B7, 32'h4c);
    chk("lui.imm", bus.out_imm_o, 32'h1234_5000);
    chk("lui.rs1", bus.out_rs1_o, 0);
    present(32'h402081B3, 32'h50);
    chk("sub.alu", bus.out_alu_op_o, 1);
    present(32'h022081B3, 32'h54);
    chk("mul.noext.ill", bus.out_illegal_o,   1);
    chk("mul.noext.we",  bus.out_rd_we_o,     0);
    chk("mul.ext.mdu",   bus_m.out_is_mdu_o,  1);
    chk("mul.ext.ill",   bus_m.out_illegal_o, 0);
    present(32'h00000833, 32'h58);
    chk("rv32e.ill",  bus_e.out_illegal_o, 1);
    chk("rv32i.ill",  bus.out_illegal_o,   0);

    drive(1, 32'h00100093, 32'h100, 0, 0);
    drive(1, 32'h00200093, 32'h104, 0, 0);
    chk("bp.a_valid", bus.out_valid_o, 1);
    chk("bp.a_pc",    bus.out_pc_o,    32'h100);
    chk("bp.rdy_b",   bus.in_ready_o,  1);
    drive(1, 32'h00300093, 32'h108, 0, 0);
    chk("bp.rdy_low", bus.in_ready_o,  0);
    chk("bp.a_held",  bus.out_pc_o,    32'h100);
    drive(1, 32'h00300093, 32'h108, 0, 0);
    chk("bp.a_stable",  bus.out_pc_o,  32'h100);
    chk("bp.a_imm",     bus.out_imm_o, 1);
    chk("bp.rdy_still", bus.in_ready_o, 0);
    bus.out_ready_i = 1;
    drive(1, 32'h00300093, 32'h108, 1, 0);
    chk("bp.b_pc",  bus.out_pc_o,    32'h104);
    chk("bp.b_imm", bus.out_imm_o,   2);
    chk("bp.rdy",   bus.in_ready_o,  1);
    drive(0, 32'h0, 32'h0, 1, 0);
    chk("bp.c_valid", bus.out_valid_o, 1);
    chk("bp.c_pc",    bus.out_pc_o,    32'h108);
    chk("bp.c_imm",   bus.out_imm_o,   3);
    drive(0, 32'h0, 32'h0, 1, 0);
    chk("bp.drained", bus.out_valid_o, 0);

    drive(1, 32'h00100093, 32'h200, 0, 0);
    drive(1, 32'h00200093, 32'h204, 0, 0);
    drive(1, 32'h00400093, 32'h208, 0, 1);
    chk("fl.pre_valid", bus.out_valid_o, 1);
    chk("fl.pre_rdy",   bus.in_ready_o,  0);
    drive(0, 32'h0, 32'h0, 1, 0);
    chk("fl.valid", bus.out_valid_o, 0);
    chk("fl.rdy",   bus.in_ready_o,  1);
    for (int i = 0; i < 3; i++) begin
      drive(0, 32'h0, 32'h0, 1, 0);
      chk("fl.nostale", bus.out_valid_o, 0);
    end

    drive(1, 32'h00500093, 32'h300, 1, 0);
    drive(1, 32'h00600093, 32'h304, 1, 0);
    #2 arst = 1;
    #1;
    chk("ar.valid", bus.out_valid_o, 0);
    chk("ar.rdy",   bus.in_ready_o,  1);
    chk("ar.pc",    bus.out_pc_o,    0);
    chk("ar.imm",   bus.out_imm_o,   0);
    chk("ar.rd",    bus.out_rd_o,    0);
    drive(0, 32'h0, 32'h0, 1, 0);
    arst = 0;
    for (int i = 0; i < 4; i++) begin
      drive(0, 32'h0, 32'h0, 1, 0);
      chk("ar.nostale", bus.out_valid_o, 0);
    end

    have = 0;
    pcn  = 32'h1000;
    for (int c = 0; c < 1500; c++) begin
      if (!have && ($urandom_range(0, 3) != 0)) begin
        gen(pcn, cur);
        pcn += 4;
        have = 1;
      end
      fl  = ($urandom_range(0, 39) == 0);
      rdy = !fl && ($urandom_range(0, 2) != 0);
      drive(have, cur.instr, cur.pc, rdy, fl);
      #1;
      if (bus.out_valid_o && rdy) begin
        chk("rnd.expected_present", q.size() != 0, 1);
        if (q.size() != 0) check_out("rnd", q.pop_front());
      end
      fired = have && bus.in_ready_o && !fl;
      if (fl) q.delete();
      else if (fired) q.push_back(cur);
      if (fired || fl) have = 0;
    end
    for (int i = 0; i < 6; i++) begin
      drive(0, 32'h0, 32'h0, 1, 0);
      #1;
      if (bus.out_valid_o) begin
        chk("drain.expected_present", q.size() != 0, 1);
        if (q.size() != 0) check_out("drain", q.pop_front());
      end
    end
    chk("drain.left", q.size(), 0);
    chk("drain.valid", bus.out_valid_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
